// File: rtl/tri_raster_ctrl.sv
// tri_raster_ctrl: bounding-box scan controller for the point-in-triangle datapath
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a scan (sampled only while idle)
//   ax..cy              : triangle vertices, latched on the accepted start
//   tri_px, tri_py      : point presented to the datapath
//   tri_s               : datapath inside result, valid LAT cycles after tri_px/tri_py
//   pix_valid/pix_ready : result stream handshake carrying pix_x, pix_y, pix_in
//   busy, done          : scan in progress, one-cycle end-of-scan pulse
//   inside_cnt          : saturating count of inside pixels of the current or last scan
module tri_raster_ctrl #(
    parameter int W    = 9,
    parameter int LAT  = 1,
    parameter int CNTW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    ax,
    input  logic [W-1:0]    ay,
    input  logic [W-1:0]    bx,
    input  logic [W-1:0]    by,
    input  logic [W-1:0]    cx,
    input  logic [W-1:0]    cy,
    output logic [W-1:0]    tri_px,
    output logic [W-1:0]    tri_py,
    input  logic            tri_s,
    output logic            pix_valid,
    output logic [W-1:0]    pix_x,
    output logic [W-1:0]    pix_y,
    output logic            pix_in,
    input  logic            pix_ready,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] inside_cnt
);
    typedef enum logic [2:0] {IDLE, BBOX, WAIT, OUT, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   xa, ya, xb, yb, xc, yc;
    logic [W-1:0]   xmin, xmax, ymin, ymax;
    logic [3:0]     wcnt;
    logic           hs, row_end, box_end;

    function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = a < b ? a : b;
        return m < c ? m : c;
    endfunction

    function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
        logic [W-1:0] m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction

    assign hs      = pix_valid & pix_ready;
    // equality tests so a box edge at 2^W-1 never wraps
    assign row_end = tri_py == ymax;
    assign box_end = tri_px == xmax;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? BBOX : IDLE;
            BBOX:    state_nx = WAIT;
            WAIT:    state_nx = wcnt == 4'd1 ? OUT : WAIT;
            OUT:     state_nx = !hs ? OUT : (row_end && box_end) ? DONE : WAIT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xa, ya, xb, yb, xc, yc} <= '0;
            {xmin, xmax, ymin, ymax} <= '0;
            tri_px     <= '0;
            tri_py     <= '0;
            wcnt       <= '0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_in     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            inside_cnt <= '0;
        end else begin
            busy <= state_nx != IDLE;
            done <= state_nx == DONE;
            case (state)
                IDLE: if (start) begin
                    {xa, ya, xb, yb, xc, yc} <= {ax, ay, bx, by, cx, cy};
                    inside_cnt <= '0;
                end
                BBOX: begin
                    xmin   <= min3(xa, xb, xc);
                    xmax   <= max3(xa, xb, xc);
                    ymin   <= min3(ya, yb, yc);
                    ymax   <= max3(ya, yb, yc);
                    tri_px <= min3(xa, xb, xc);
                    tri_py <= min3(ya, yb, yc);
                    wcnt   <= 4'(LAT);
                end
                WAIT: begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt == 4'd1) begin
                        pix_in    <= tri_s;
                        pix_x     <= tri_px;
                        pix_y     <= tri_py;
                        pix_valid <= 1'b1;
                    end
                end
                OUT: if (hs) begin
                    pix_valid <= 1'b0;
                    wcnt      <= 4'(LAT);
                    if (pix_in && inside_cnt != {CNTW{1'b1}})
                        inside_cnt <= inside_cnt + CNTW'(1);
                    if (!row_end)
                        tri_py <= tri_py + W'(1);
                    else if (!box_end) begin
                        tri_px <= tri_px + W'(1);
                        tri_py <= ymin;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
